// File: rtl/uart_dbg_ctrl.sv
// UART debug-loader controller: parses Read/Write/Exec frames from the host byte
// stream and sequences single-outstanding OBI word accesses and exec requests.
module uart_dbg_ctrl #(
    parameter int unsigned TimeoutCycles = 65535,
    parameter int unsigned ExecDataWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_valid_i,
    output logic                     rx_ready_o,
    output logic [7:0]               tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic                     obi_req_o,
    input  logic                     obi_gnt_i,
    output logic [31:0]              obi_addr_o,
    output logic                     obi_we_o,
    output logic [3:0]               obi_be_o,
    output logic [31:0]              obi_wdata_o,
    input  logic                     obi_rvalid_i,
    input  logic [31:0]              obi_rdata_i,
    input  logic                     obi_err_i,
    output logic [ExecDataWidth:0]   exec_req_o,
    input  logic                     exec_done_i,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam logic [7:0] CMD_READ  = 8'h11;
    localparam logic [7:0] CMD_WRITE = 8'h12;
    localparam logic [7:0] CMD_EXEC  = 8'h13;
    localparam logic [7:0] BYTE_ACK  = 8'h06;
    localparam logic [7:0] BYTE_EOT  = 8'h04;
    localparam logic [7:0] BYTE_EOC  = 8'h14;
    localparam int unsigned TimerWidth = $clog2(TimeoutCycles + 1);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

    typedef enum logic [3:0] {
        IDLE, HDR_ADDR, HDR_LEN, TX_ACK, RD_REQ, RD_WAIT, RD_TX,
        WR_RX, WR_REQ, WR_WAIT, TX_EOT, EXEC, EXEC_WAIT, TX_EOC
    } state_t;

    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_EXEC} op_t;

    state_t                state, state_next;
    op_t                   op;
    logic [31:0]           addr;
    logic [31:0]           data;
    logic [1:0]            byte_cnt;
    logic [8:0]            words;
    logic [TimerWidth-1:0] timer;
    logic                  err;

    logic is_cmd, last_byte, last_word, timing, timed_out;

    assign is_cmd    = (rx_data_i == CMD_READ) || (rx_data_i == CMD_WRITE) || (rx_data_i == CMD_EXEC);
    assign last_byte = (byte_cnt == 2'd3);
    assign last_word = (words == 9'd1);
    assign timing    = (state == HDR_ADDR) || (state == HDR_LEN) || (state == WR_RX);
    assign timed_out = timing && !rx_valid_i && (timer == TimerLast);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output and next_state gets a default first so no path leaves them unassigned (no latches).
    always_comb begin
        state_next = state;
        rx_ready_o = 1'b0;
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        obi_req_o  = 1'b0;
        obi_we_o   = 1'b0;
        unique case (state)
            IDLE: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i && is_cmd) state_next = HDR_ADDR;
            end
            HDR_ADDR: begin
                rx_ready_o = 1'b1;
                if (timed_out) state_next = IDLE;
                else if (rx_valid_i && last_byte) state_next = (op == OP_EXEC) ? TX_ACK : HDR_LEN;
            end
            HDR_LEN: begin
                rx_ready_o = 1'b1;
                if (timed_out) state_next = IDLE;
                else if (rx_valid_i) state_next = TX_ACK;
            end
            TX_ACK: begin
                tx_valid_o = 1'b1;
                tx_data_o  = BYTE_ACK;
                if (tx_ready_i) begin
                    unique case (op)
                        OP_READ:  state_next = RD_REQ;
                        OP_WRITE: state_next = WR_RX;
                        default:  state_next = EXEC;
                    endcase
                end
            end
            RD_REQ: begin
                obi_req_o = 1'b1;
                if (obi_gnt_i) state_next = RD_WAIT;
            end
            RD_WAIT: if (obi_rvalid_i) state_next = RD_TX;
            RD_TX: begin
                tx_valid_o = 1'b1;
                tx_data_o  = data[7:0];
                if (tx_ready_i && last_byte) state_next = last_word ? TX_EOT : RD_REQ;
            end
            WR_RX: begin
                rx_ready_o = 1'b1;
                if (timed_out) state_next = IDLE;
                else if (rx_valid_i && last_byte) state_next = WR_REQ;
            end
            WR_REQ: begin
                obi_req_o = 1'b1;
                obi_we_o  = 1'b1;
                if (obi_gnt_i) state_next = WR_WAIT;
            end
            WR_WAIT: if (obi_rvalid_i) state_next = last_word ? TX_EOT : WR_RX;
            TX_EOT: begin
                tx_valid_o = 1'b1;
                tx_data_o  = BYTE_EOT;
                if (tx_ready_i) state_next = IDLE;
            end
            EXEC:      state_next = EXEC_WAIT;
            EXEC_WAIT: if (exec_done_i) state_next = TX_EOC;
            TX_EOC: begin
                tx_valid_o = 1'b1;
                tx_data_o  = BYTE_EOC;
                if (tx_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Outputs read 0 while reset is held, even though IDLE normally accepts bytes.
        if (rst_i) rx_ready_o = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only; comb logic above uses blocking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op       <= OP_READ;
            addr     <= '0;
            data     <= '0;
            byte_cnt <= '0;
            words    <= '0;
            timer    <= '0;
            err      <= 1'b0;
        end else begin
            timer <= (timing && !rx_valid_i && !timed_out) ? timer + TimerWidth'(1) : '0;
            if (timed_out) err <= 1'b1;
            unique case (state)
                IDLE: if (rx_valid_i && is_cmd) begin
                    op       <= (rx_data_i == CMD_READ)  ? OP_READ :
                                (rx_data_i == CMD_WRITE) ? OP_WRITE : OP_EXEC;
                    err      <= 1'b0;
                    byte_cnt <= '0;
                end
                HDR_ADDR: if (rx_valid_i) begin
                    addr     <= {rx_data_i, addr[31:8]};
                    byte_cnt <= byte_cnt + 2'd1;
                end
                HDR_LEN: if (rx_valid_i) words <= (rx_data_i == 8'h00) ? 9'd256 : {1'b0, rx_data_i};
                RD_WAIT: if (obi_rvalid_i) begin
                    data     <= obi_rdata_i;
                    byte_cnt <= '0;
                    if (obi_err_i) err <= 1'b1;
                end
                RD_TX: if (tx_ready_i) begin
                    data     <= data >> 8;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (last_byte) begin
                        addr  <= addr + 32'd4;
                        words <= words - 9'd1;
                    end
                end
                WR_RX: if (rx_valid_i) begin
                    data     <= {rx_data_i, data[31:8]};
                    byte_cnt <= byte_cnt + 2'd1;
                end
                WR_WAIT: if (obi_rvalid_i) begin
                    addr  <= addr + 32'd4;
                    words <= words - 9'd1;
                    if (obi_err_i) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign obi_addr_o  = obi_req_o ? {addr[31:2], 2'b00} : 32'h0;
    assign obi_be_o    = obi_req_o ? 4'hF : 4'h0;
    assign obi_wdata_o = obi_we_o ? data : 32'h0;
    assign exec_req_o  = (state == EXEC) ? {addr[ExecDataWidth-1:0], 1'b1} : '0;
    assign busy_o      = (state != IDLE);
    assign err_o       = err;

endmodule

// File: tb/tb_uart_dbg_ctrl.sv
// Scoreboard bench for uart_dbg_ctrl: a frame-level model predicts tx bytes, OBI
// accesses and exec requests; independent monitors compare what the DUT emits.
module tb_uart_dbg_ctrl;

    localparam int unsigned TO = 64;
    localparam logic [7:0] ACK = 8'h06, EOT = 8'h04, EOC = 8'h14;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0, rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o, tx_ready_i = 1'b0;
    logic        obi_req_o, obi_gnt_i = 1'b0, obi_we_o;
    logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i = '0;
    logic [3:0]  obi_be_o;
    logic        obi_rvalid_i = 1'b0, obi_err_i = 1'b0;
    logic [32:0] exec_req_o;
    logic        exec_done_i = 1'b0, busy_o, err_o;

    always #5 clk_i = ~clk_i;

    uart_dbg_ctrl #(.TimeoutCycles(TO), .ExecDataWidth(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
        .exec_req_o(exec_req_o), .exec_done_i(exec_done_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } obi_txn_t;

    int unsigned vectors = 0, miscompares = 0;
    logic [7:0]  exp_tx[$];
    obi_txn_t    exp_obi[$];
    logic [31:0] exp_exec[$];
    logic [31:0] wr_words[$];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] slave_mem[logic [31:0]];
    bit          exp_err = 1'b0;
    int          tx_mode = 2;      // 0 random, 1 toggle, 2 always ready
    int          gnt_mode = 0;     // 0 random 0..3 cycles, 1 fixed 5 cycles
    int          err_inject = 0;
    int          rsp_hold = 0;
    bit          outstanding = 1'b0;
    int          exec_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] slave_read(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
    endfunction

    // Transmit side is always driven just after the rising edge.
    initial forever begin
        @(posedge clk_i); #1;
        case (tx_mode)
            0:       tx_ready_i = 1'($urandom_range(0, 1));
            1:       tx_ready_i = ~tx_ready_i;
            default: tx_ready_i = 1'b1;
        endcase
    end

    // Tx monitor: byte order against the scoreboard, and stability while stalled.
    initial begin
        bit         pending = 1'b0;
        logic [7:0] held = '0;
        forever begin
            @(negedge clk_i);
            if (tx_valid_o) begin
                if (pending) check("tx_data_stable", tx_data_o, held);
                if (tx_ready_i) begin
                    check("tx_expected_pending", exp_tx.size() > 0, 1);
                    if (exp_tx.size() > 0) check("tx_byte", tx_data_o, exp_tx.pop_front());
                    pending = 1'b0;
                end else begin
                    pending = 1'b1;
                    held    = tx_data_o;
                end
            end else begin
                if (pending && !rst_i) check("tx_valid_held", tx_valid_o, 1'b1);
                pending = 1'b0;
            end
        end
    end

    // OBI subordinate + monitor: grants with configurable delay, one response per grant.
    initial begin
        int          gnt_wait = 0, rsp_delay = 0;
        bit          waiting = 1'b0;
        obi_txn_t    held, cur;
        forever begin
            @(negedge clk_i);
            obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_rdata_i = '0;
            if (obi_req_o && waiting) begin
                check("obi_addr_stable", obi_addr_o, held.addr);
                check("obi_we_stable", obi_we_o, held.we);
                check("obi_wdata_stable", obi_wdata_o, held.wdata);
            end
            waiting = 1'b0;
            if (outstanding) begin
                if (obi_req_o) check("obi_single_outstanding", obi_req_o, 1'b0);
                if (rsp_delay == 0) begin
                    obi_rvalid_i = 1'b1;
                    if (cur.we) slave_mem[cur.addr] = cur.wdata;
                    else        obi_rdata_i = slave_read(cur.addr);
                    if (err_inject > 0) begin
                        obi_err_i = 1'b1;
                        err_inject--;
                    end
                    outstanding = 1'b0;
                end else rsp_delay--;
            end else if (obi_req_o) begin
                if (gnt_wait == 0) begin
                    obi_gnt_i = 1'b1;
                    cur = '{obi_addr_o, obi_we_o, obi_wdata_o};
                    check("obi_be", obi_be_o, 4'hF);
                    check("obi_expected_pending", exp_obi.size() > 0, 1);
                    if (exp_obi.size() > 0) begin
                        obi_txn_t e;
                        e = exp_obi.pop_front();
                        check("obi_addr", obi_addr_o, e.addr);
                        check("obi_we", obi_we_o, e.we);
                        if (e.we) check("obi_wdata", obi_wdata_o, e.wdata);
                    end
                    outstanding = 1'b1;
                    rsp_delay   = (rsp_hold > 0) ? rsp_hold : $urandom_range(0, 2);
                    gnt_wait    = (gnt_mode == 1) ? 5 : $urandom_range(0, 3);
                end else begin
                    gnt_wait--;
                    waiting = 1'b1;
                    held    = '{obi_addr_o, obi_we_o, obi_wdata_o};
                end
            end
        end
    end

    // Exec monitor: single-cycle pulse carrying the expected address.
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (exec_req_o[0]) begin
                check("exec_pulse_single", prev, 1'b0);
                check("exec_expected_pending", exp_exec.size() > 0, 1);
                if (exp_exec.size() > 0) check("exec_addr", exec_req_o[32:1], exp_exec.pop_front());
                exec_count++;
            end
            prev = exec_req_o[0];
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(negedge clk_i);
        while (!rx_ready_o && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        if (!rx_ready_o) check("rx_accept", rx_ready_o, 1'b1);
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b, input int gap_max);
        send_byte(b);
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] addr, input int gap_max);
        send_gap(cmd, gap_max);
        for (int b = 0; b < 4; b++) send_gap(addr[8*b +: 8], gap_max);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy_o || exp_tx.size() > 0 || exp_obi.size() > 0) && n < 20000) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        check({name, "_idle"}, busy_o, 1'b0);
        check({name, "_tx_drained"}, exp_tx.size(), 0);
        check({name, "_obi_drained"}, exp_obi.size(), 0);
        check({name, "_err"}, err_o, exp_err);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] n8, input int gap_max, input bit inject);
        int          words;
        logic [31:0] a, w;
        words   = (n8 == 8'd0) ? 256 : int'(n8);
        exp_err = inject;
        if (inject) err_inject = 1;
        exp_tx.push_back(ACK);
        for (int i = 0; i < words; i++) begin
            a = {addr[31:2], 2'b00} + 32'(4 * i);
            exp_obi.push_back('{a, 1'b0, 32'h0});
            w = model_read(a);
            for (int b = 0; b < 4; b++) exp_tx.push_back(w[8*b +: 8]);
        end
        exp_tx.push_back(EOT);
        send_hdr(8'h11, addr, gap_max);
        send_gap(n8, gap_max);
        wait_idle("read");
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] n8, input int gap_max, input bit inject);
        int          words;
        logic [31:0] a, w;
        logic [7:0]  data_q[$];
        words   = (n8 == 8'd0) ? 256 : int'(n8);
        exp_err = inject;
        if (inject) err_inject = 1;
        exp_tx.push_back(ACK);
        for (int i = 0; i < words; i++) begin
            a = {addr[31:2], 2'b00} + 32'(4 * i);
            w = (wr_words.size() > 0) ? wr_words.pop_front() : $urandom;
            model_mem[a] = w;
            exp_obi.push_back('{a, 1'b1, w});
            for (int b = 0; b < 4; b++) data_q.push_back(w[8*b +: 8]);
        end
        exp_tx.push_back(EOT);
        send_hdr(8'h12, addr, gap_max);
        send_gap(n8, gap_max);
        foreach (data_q[i]) send_gap(data_q[i], gap_max);
        wait_idle("write");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          ec;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_rx_ready", rx_ready_o, 1'b0);
        check("rst_tx_valid", tx_valid_o, 1'b0);
        check("rst_obi_req", obi_req_o, 1'b0);
        check("rst_exec_req", exec_req_o, 33'h0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("idle_rx_ready", rx_ready_o, 1'b1);

        // Directed write then read-back.
        wr_words.push_back(32'h1234_5678);
        wr_words.push_back(32'hDEAD_BEEF);
        do_write(32'h1000_0000, 8'd2, 2, 1'b0);
        check("mem_10000000", slave_read(32'h1000_0000), 32'h1234_5678);
        check("mem_10000004", slave_read(32'h1000_0004), 32'hDEAD_BEEF);
        do_read(32'h1000_0000, 8'd2, 2, 1'b0);

        // Backpressure on both grant and transmit.
        gnt_mode = 1; tx_mode = 1;
        do_write(32'h1000_0100, 8'd2, 0, 1'b0);
        do_read(32'h1000_0000, 8'd2, 0, 1'b0);
        gnt_mode = 0; tx_mode = 2;

        // Address wrap and N=0 meaning 256 words.
        do_read(32'hFFFF_FFFC, 8'd2, 1, 1'b0);
        tx_mode = 0;
        do_read($urandom, 8'd0, 0, 1'b0);
        tx_mode = 2;

        // Unknown byte in IDLE is dropped.
        send_byte(8'h55);
        repeat (3) @(posedge clk_i);
        #1;
        check("drop_busy", busy_o, 1'b0);
        check("drop_err", err_o, 1'b0);

        // Error response: data passes through, err sticks, a junk byte leaves it set.
        do_read(32'h2000_0000, 8'd2, 1, 1'b1);
        send_byte(8'h55);
        repeat (2) @(posedge clk_i);
        #1;
        check("err_sticky", err_o, 1'b1);
        do_write(32'h2000_0010, 8'd1, 1, 1'b0);

        // Exec.
        exp_err = 1'b0;
        exp_tx.push_back(ACK);
        exp_tx.push_back(EOC);
        exp_exec.push_back(32'h1000_0080);
        ec = exec_count;
        send_hdr(8'h13, 32'h1000_0080, 1);
        n = 0;
        while (exec_count == ec && n < 2000) begin
            @(posedge clk_i);
            n++;
        end
        check("exec_pulse_seen", exec_count, ec + 1);
        repeat (100) @(posedge clk_i);
        #1;
        check("exec_busy_waiting", busy_o, 1'b1);
        check("exec_eoc_not_early", exp_tx.size(), 1);
        exec_done_i = 1'b1;
        wait_idle("exec");
        exec_done_i = 1'b0;

        // Timeout mid write data: Ack only, no OBI access, err set.
        exp_tx.push_back(ACK);
        send_hdr(8'h12, 32'h3000_0000, 0);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        repeat (TO - 14) @(posedge clk_i);
        #1;
        check("timeout_not_early_busy", busy_o, 1'b1);
        check("timeout_not_early_err", err_o, 1'b0);
        repeat (30) @(posedge clk_i);
        #1;
        check("timeout_busy", busy_o, 1'b0);
        check("timeout_err", err_o, 1'b1);
        check("timeout_tx_drained", exp_tx.size(), 0);

        // Reset while the read response is outstanding.
        rsp_hold = 20;
        exp_tx.push_back(ACK);
        exp_obi.push_back('{32'h1000_0000, 1'b0, 32'h0});
        send_hdr(8'h11, 32'h1000_0000, 0);
        send_byte(8'h01);
        n = 0;
        while (!outstanding && n < 2000) begin
            @(posedge clk_i);
            n++;
        end
        @(posedge clk_i); #1;
        check("rdwait_busy", busy_o, 1'b1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("rst2_rx_ready", rx_ready_o, 1'b0);
        check("rst2_tx_valid", tx_valid_o, 1'b0);
        check("rst2_tx_data", tx_data_o, 8'h00);
        check("rst2_obi_req", obi_req_o, 1'b0);
        check("rst2_obi_addr", obi_addr_o, 32'h0);
        check("rst2_obi_we", obi_we_o, 1'b0);
        check("rst2_obi_be", obi_be_o, 4'h0);
        check("rst2_obi_wdata", obi_wdata_o, 32'h0);
        check("rst2_exec_req", exec_req_o, 33'h0);
        check("rst2_busy", busy_o, 1'b0);
        check("rst2_err", err_o, 1'b0);
        @(posedge clk_i); #1;
        rst_i    = 1'b0;
        rsp_hold = 0;
        exp_err  = 1'b0;
        repeat (25) @(posedge clk_i);
        #1;
        check("post_rst_busy", busy_o, 1'b0);
        check("post_rst_tx_valid", tx_valid_o, 1'b0);

        // Randomized traffic.
        tx_mode = 0;
        for (int t = 0; t < 10; t++) begin
            logic [31:0] a;
            logic [7:0]  len;
            bit          inj;
            a   = {4'h4, 20'($urandom), 8'($urandom_range(0, 15) * 4)};
            len = 8'($urandom_range(1, 6));
            inj = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) do_write(a, len, 3, inj);
            else                           do_read(a, len, 3, inj);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_dbg_ctrl.md
Name: uart_dbg_ctrl

Overview:
- UART debug-loader controller: parses a host byte stream (Read 0x11, Write 0x12, Exec 0x13) and sequences OBI memory accesses, replying with Ack 0x06, data, Eot 0x04 and Eoc 0x14.
- Sits between the UART byte interface and an OBI manager port on the SoC crossbar.
- Provides a JTAG-free load/run path for binaries.

Parameters:
- TimeoutCycles, 65535: idle cycles allowed between host bytes inside a command before the command is aborted.
- ExecDataWidth, 32: width of the exec address.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  received byte valid
- rx_ready_o  out  1  byte accepted when rx_valid_i && rx_ready_o
- tx_data_o  out  8  byte to transmit
- tx_valid_o  out  1  transmit request
- tx_ready_i  in  1  transmitter accepts byte
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  32  word address; bits [1:0] always 0
- obi_we_o  out  1  write enable
- obi_be_o  out  4  byte enables; always 4'hF
- obi_wdata_o  out  32  write data
- obi_rvalid_i  in  1  response valid
- obi_rdata_i  in  32  read data
- obi_err_i  in  1  response error, qualified by rvalid
- exec_req_o  out  ExecDataWidth+1  bit 0 is a one-cycle exec pulse; upper bits carry the exec address
- exec_done_i  in  1  core reports end of computation
- busy_o  out  1  high whenever FSM not in IDLE
- err_o  out  1  sticky error flag; cleared when a new valid command byte is accepted

Behaviour:
- Reset: reset is synchronous and active-high; on a clk_i edge with rst_i=1 the FSM goes to IDLE, counters clear, and every output is 0. This holds even mid-command; in-flight OBI responses after reset are ignored.
- Frames (multi-byte fields little-endian):
  - Read: 0x11, A0..A3, N. Reply Ack, then N words (4 bytes each, LSB first), then Eot.
  - Write: 0x12, A0..A3, N. Ack is sent after N; the host then sends 4N bytes. Eot is sent after the last write response.
  - Exec: 0x13, A0..A3. Reply Ack, pulse exec_req_o bit 0 with the address, wait for exec_done_i, reply Eoc.
- N=0 means 256 words. The address increments by 4 per word and wraps modulo 2^32.
- FSM states: IDLE, HDR_ADDR, HDR_LEN, TX_ACK, RD_REQ, RD_WAIT, RD_TX, WR_RX, WR_REQ, WR_WAIT, TX_EOT, EXEC, EXEC_WAIT, TX_EOC.
- IDLE:
  - rx_ready_o=1.
  - 0x11 / 0x12 / 0x13 -> HDR_ADDR.
  - Any other byte is consumed and dropped; stay in IDLE, err_o unchanged.
- rx_ready_o is 1 only in IDLE, HDR_ADDR, HDR_LEN and WR_RX. One byte is accepted per cycle.
- tx handshake: tx_valid_o and tx_data_o stay stable until tx_ready_i. The next byte is presented no earlier than the cycle after acceptance.
- OBI handshake:
  - obi_req_o, obi_addr_o, obi_we_o and obi_wdata_o are held stable until obi_gnt_i.
  - At most one outstanding transaction.
  - req drops the cycle after gnt.
  - rvalid is only sampled in *_WAIT, and arrives at least one cycle after gnt.
- Read path: RD_REQ -> gnt -> RD_WAIT -> rvalid latches rdata -> RD_TX sends 4 bytes -> next word, or TX_EOT when the count is exhausted.
- Write path: WR_RX assembles 4 bytes -> WR_REQ -> WR_WAIT -> rvalid -> next word, or TX_EOT.
- obi_err_i with rvalid:
  - Sets err_o.
  - The read word is sent as received; the transfer continues. The frame length never changes.
- Timeout:
  - Applies in HDR_ADDR, HDR_LEN and WR_RX.
  - The counter resets on each accepted byte.
  - Reaching TimeoutCycles with no byte sets err_o and returns to IDLE; no Eot is sent.
  - Partially assembled write words are discarded, never written.
- Exec: EXEC pulses exec_req_o bit 0 for exactly one cycle, then EXEC_WAIT. exec_done_i high (level, any cycle from EXEC_WAIT on) -> TX_EOC -> IDLE.
- Simultaneous events: rx_valid_i while in a TX/OBI state is not accepted (rx_ready_o=0); the host holds it.

Test Plan:
- Write 0x12, 00 00 00 10, N=02, bytes 78 56 34 12 EF BE AD DE -> tx 0x06; OBI writes 0x10000000=0x12345678 and 0x10000004=0xDEADBEEF, be=F; tx 0x04; err_o=0.
- Read 0x11, 00 00 00 10, N=02 with memory from the previous test -> tx 06 78 56 34 12 EF BE AD DE 04.
- Backpressure: gnt delayed 5 cycles and tx_ready_i toggling 1/0 -> addr, wdata and tx_data stable while unaccepted; byte sequence identical to the unstalled case.
- Boundaries:
  - Read at FFFFFFFC with N=02 -> accesses FFFFFFFC then 00000000.
  - N=00 -> exactly 256 words then Eot.
- Exec 0x13, 80 00 00 10 -> tx 06; single-cycle exec pulse with address 0x10000080; exec_done_i after 100 cycles -> tx 0x14; busy_o falls.
- Errors and recovery:
  - Byte 0x55 in IDLE is dropped.
  - Write header followed by 3 data bytes then silence -> after TimeoutCycles, err_o=1, no OBI request, IDLE.
  - rst_i asserted in RD_WAIT -> all outputs 0 next cycle.
